// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_pkg
// Brief    : Shared state encoding, ASCII constants and hex helpers for the
//            serial command sequencer.
// Revision : 1.0  initial release
// ============================================================================
package serial_cmd_pkg;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT_DP = 3'd3;
  localparam logic [2:0] ST_TX_HEX  = 3'd4;
  localparam logic [2:0] ST_TX_NL   = 3'd5;
  localparam logic [2:0] ST_TX_ERR  = 3'd6;

  // Protocol characters
  localparam logic [7:0] CH_H   = 8'h68;  // 'h' : start of command
  localparam logic [7:0] CH_G   = 8'h67;  // 'g' : go
  localparam logic [7:0] CH_NL  = 8'h0A;  // '\n': end of result line
  localparam logic [7:0] CH_ERR = 8'h3F;  // '?' : error reply

  // True for '0'-'9', 'a'-'f', 'A'-'F'
  function automatic logic is_hex(input logic [7:0] ch);
    return ((ch >= 8'h30) && (ch <= 8'h39)) ||
           ((ch >= 8'h61) && (ch <= 8'h66)) ||
           ((ch >= 8'h41) && (ch <= 8'h46));
  endfunction

  // ASCII hex digit to nibble; only meaningful when is_hex(ch) holds
  function automatic logic [3:0] hex2nib(input logic [7:0] ch);
    logic [7:0] v;
    v = 8'h00;
    if (ch <= 8'h39)      v = ch - 8'h30;
    else if (ch >= 8'h61) v = ch - 8'h57;
    else                  v = ch - 8'h37;
    return v[3:0];
  endfunction

  // Nibble to lowercase ASCII hex digit
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_byte_sender.sv
`default_nettype none
// ============================================================================
// Module   : tx_byte_sender
// Brief    : Issues one-cycle new_tx_data strobes for a held send request.
//            A strobe is only issued when tx_busy is low and no strobe was
//            issued in the previous cycle; the enforced gap lets a
//            transmitter raise tx_busy one cycle late without being overrun.
// Revision : 1.0  initial release
// ============================================================================
module tx_byte_sender (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  input  logic       req,          // byte_in is pending
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  output logic       accepted      // byte_in has been handed to the transmitter
);

  logic       r_strobe;
  logic [7:0] r_data;
  logic       w_fire;

  // Fire when a byte is pending, the transmitter is idle and the gap cycle has elapsed
  always_comb begin
    w_fire = req && !tx_busy && !r_strobe;
  end

  // Register strobe and data so the outputs are glitch-free and clear on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strobe <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_strobe <= w_fire;
      if (w_fire) begin
        r_data <= byte_in;
      end
    end
  end

  assign tx_data     = r_data;
  assign new_tx_data = r_strobe;
  // The request stays asserted through the strobe cycle; the gap rule blocks a repeat
  assign accepted    = r_strobe;

endmodule
`default_nettype wire

// File: rtl/serial_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_sequencer
// Brief    : Parses 'h' + NDIG hex digits + 'g' from the UART receiver, issues
//            the operand to the datapath, then returns the result as lowercase
//            ASCII hex followed by '\n' ('?' on parse error or timeout).
// Revision : 1.0  initial release
// ============================================================================
module serial_cmd_sequencer
  import serial_cmd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] dp_operand,
  output logic              dp_start,
  input  logic              dp_done,
  input  logic [DATA_W-1:0] dp_result,
  output logic [7:0]        ledout
);

  localparam int NDIG  = DATA_W / 4;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CNT_W-1:0] NDIG_C     = CNT_W'(NDIG);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);
  // The ISSUE cycle already counts as the first cycle of the wait window
  localparam logic [15:0]      TIMER_LOAD = 16'(TIMEOUT - 1);

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_operand;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic [15:0]       r_timer;
  logic              r_flag_drop;
  logic              r_flag_to;
  logic              r_flag_err;
  logic              r_dp_start;
  logic [DATA_W-1:0] r_dp_operand;

  logic              w_tx_req;
  logic [7:0]        w_tx_byte;
  logic              w_accepted;
  logic              w_busy;
  logic [3:0]        w_cnt_led;

  // Select the byte offered to the transmitter from the current TX state
  always_comb begin
    w_tx_req  = 1'b0;
    w_tx_byte = 8'h00;
    case (r_state)
      ST_TX_HEX: begin
        w_tx_req  = 1'b1;
        w_tx_byte = nib2hex(r_shift[DATA_W-1 -: 4]);
      end
      ST_TX_NL: begin
        w_tx_req  = 1'b1;
        w_tx_byte = CH_NL;
      end
      ST_TX_ERR: begin
        w_tx_req  = 1'b1;
        w_tx_byte = CH_ERR;
      end
      default: begin
        w_tx_req  = 1'b0;
        w_tx_byte = 8'h00;
      end
    endcase
  end

  tx_byte_sender u_tx_byte_sender (
    .clk         (clk),
    .rst         (rst),
    .req         (w_tx_req),
    .byte_in     (w_tx_byte),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .accepted    (w_accepted)
  );

  // Command parser, datapath handshake and reply sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_operand    <= '0;
      r_count      <= '0;
      r_shift      <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_flag_drop  <= 1'b0;
      r_flag_to    <= 1'b0;
      r_flag_err   <= 1'b0;
      r_dp_start   <= 1'b0;
      r_dp_operand <= '0;
    end else begin
      r_dp_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (new_rx_data && (rx_data == CH_H)) begin
            r_state     <= ST_LOAD;
            r_operand   <= '0;
            r_count     <= '0;
            r_flag_drop <= 1'b0;
            r_flag_to   <= 1'b0;
            r_flag_err  <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (new_rx_data) begin
            if (rx_data == CH_H) begin
              r_operand <= '0;
              r_count   <= '0;
            end else if (rx_data == CH_G) begin
              if (r_count == NDIG_C) begin
                r_state <= ST_ISSUE;
              end else begin
                r_state    <= ST_TX_ERR;
                r_flag_err <= 1'b1;
              end
            end else if (is_hex(rx_data) && (r_count != NDIG_C)) begin
              r_operand <= (r_operand << 4) | DATA_W'(hex2nib(rx_data));
              r_count   <= r_count + 1'b1;
            end else begin
              // Non-hex byte, or a digit beyond the operand width
              r_state    <= ST_TX_ERR;
              r_flag_err <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          r_dp_start   <= 1'b1;
          r_dp_operand <= r_operand;
          r_timer      <= TIMER_LOAD;
          r_state      <= ST_WAIT_DP;
        end

        ST_WAIT_DP: begin
          // Completion wins over expiry in the same cycle
          if (dp_done) begin
            r_shift <= dp_result;
            r_idx   <= IDX_LAST;
            r_state <= ST_TX_HEX;
          end else if (r_timer <= 16'd1) begin
            r_flag_to <= 1'b1;
            r_state   <= ST_TX_ERR;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_TX_HEX: begin
          if (w_accepted) begin
            r_shift <= r_shift << 4;
            if (r_idx == '0) begin
              r_state <= ST_TX_NL;
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end
        end

        ST_TX_NL, ST_TX_ERR: begin
          if (w_accepted) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Bytes arriving while a command is in flight are lost; remember that
      if (new_rx_data && (r_state != ST_IDLE) && (r_state != ST_LOAD)) begin
        r_flag_drop <= 1'b1;
      end
    end
  end

  // Status LEDs: sticky flags, busy indication and saturated digit count
  always_comb begin
    w_busy    = (r_state != ST_IDLE) && (r_state != ST_LOAD);
    w_cnt_led = (r_count > CNT_W'(15)) ? 4'hF : 4'(r_count);
    ledout    = {r_flag_drop, r_flag_to, r_flag_err, w_busy, w_cnt_led};
  end

  assign dp_operand = r_dp_operand;
  assign dp_start   = r_dp_start;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_cmd_sequencer
// Brief    : Self-checking bench for serial_cmd_sequencer. Datapath model
//            returns operand+1 five cycles after dp_start; expected tx bytes
//            and operands are queued when a command is sent and compared as
//            the DUT produces them.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_cmd_sequencer;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              new_rx_data = 1'b0;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              tx_busy = 1'b0;
  logic [DATA_W-1:0] dp_operand;
  logic              dp_start;
  logic              dp_done = 1'b0;
  logic [DATA_W-1:0] dp_result = '0;
  logic [7:0]        ledout;

  serial_cmd_sequencer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .dp_operand  (dp_operand),
    .dp_start    (dp_start),
    .dp_done     (dp_done),
    .dp_result   (dp_result),
    .ledout      (ledout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]        q_tx[$];
  logic [DATA_W-1:0] q_op[$];

  int n_strobes       = 0;
  int n_starts        = 0;
  int last_strobe_cyc = 0;
  int start_cyc       = 0;
  int last_g_cyc      = 0;
  logic prev_strobe   = 1'b0;
  logic busy_mode     = 1'b0;
  int   busy_cnt      = 0;
  logic dp_hang       = 1'b0;
  int   dp_cnt        = 0;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Transmit monitor plus a transmitter model that stays busy after each strobe
  always @(negedge clk) begin
    if (new_tx_data) begin
      n_strobes++;
      last_strobe_cyc = cyc;
      check("tx_while_busy", tx_busy == 1'b0, 64'(tx_busy), 64'd0);
      check("tx_back_to_back", prev_strobe == 1'b0, 64'(prev_strobe), 64'd0);
      if (q_tx.size() == 0) begin
        n_checks++;
        $display("FAIL tx_unexpected: got byte %0h, required no strobe", tx_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = q_tx.pop_front();
        check("tx_byte", tx_data == exp_b, 64'(tx_data), 64'(exp_b));
      end
    end
    prev_strobe = new_tx_data;
    if (busy_cnt > 0) busy_cnt--;
    if (new_tx_data && busy_mode) busy_cnt = 20;
    tx_busy = (busy_cnt > 0);
  end

  // Datapath model: result = operand + 1, dp_done five cycles after dp_start
  always @(negedge clk) begin
    dp_done = 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0) dp_done = 1'b1;
    end
    if (dp_start) begin
      n_starts++;
      start_cyc = cyc;
      check("g_to_start_latency", cyc == last_g_cyc + 2, 64'(cyc - last_g_cyc), 64'd2);
      if (q_op.size() == 0) begin
        n_checks++;
        $display("FAIL dp_unexpected: got dp_start operand %0h, required no start", dp_operand);
      end else begin
        logic [DATA_W-1:0] exp_op;
        exp_op = q_op.pop_front();
        check("dp_operand", dp_operand == exp_op, 64'(dp_operand), 64'(exp_op));
      end
      dp_result = dp_operand + 1'b1;
      if (!dp_hang) dp_cnt = 5;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    new_rx_data = 1'b1;
    if (b == 8'h67) last_g_cyc = cyc;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_resp(input string s);
    for (int i = 0; i < s.len(); i++) q_tx.push_back(s[i]);
  endtask

  task automatic wait_tx_empty(input int budget);
    int n;
    n = 0;
    while (q_tx.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_tx.size() != 0) begin
      n_checks++;
      $display("FAIL tx_timeout: got %0d bytes pending, required 0", q_tx.size());
      q_tx.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"},     tx_data == 8'h00,  64'(tx_data),     64'd0);
    check({tag, "_new_tx_data"}, new_tx_data == 0,  64'(new_tx_data), 64'd0);
    check({tag, "_dp_operand"},  dp_operand == '0,  64'(dp_operand),  64'd0);
    check({tag, "_dp_start"},    dp_start == 0,     64'(dp_start),    64'd0);
    check({tag, "_ledout"},      ledout == 8'h00,   64'(ledout),      64'd0);
  endtask

  typedef struct {
    string             cmd;
    string             resp;
    logic [DATA_W-1:0] op;
    int                starts;
    logic [7:0]        led;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    int sbase;
    sbase = n_starts;
    push_resp(v.resp);
    if (v.starts != 0) q_op.push_back(v.op);
    send_str(v.cmd);
    wait_tx_empty(1000);
    repeat (4) @(negedge clk);
    check({"starts_", v.cmd}, n_starts - sbase == v.starts,
          64'(n_starts - sbase), 64'(v.starts));
    check({"ledout_", v.cmd}, ledout == v.led, 64'(ledout), 64'(v.led));
    q_op.delete();
  endtask

  initial begin
    int base;
    int sbase;
    int n;

    vecs[0] = '{"h91230001g",    "91230002\n", 32'h91230001, 1, 8'h08};
    vecs[1] = '{"h1834567g",     "?",          32'h0,        0, 8'h27};
    vecs[2] = '{"h00000000g",    "00000001\n", 32'h00000000, 1, 8'h08};
    vecs[3] = '{"xyzh0000000Ag", "0000000b\n", 32'h0000000A, 1, 8'h08};
    vecs[4] = '{"hFFFFFFFFg",    "00000000\n", 32'hFFFFFFFF, 1, 8'h08};
    vecs[5] = '{"h123456789",    "?",          32'h0,        0, 8'h28};
    vecs[6] = '{"h12x",          "?",          32'h0,        0, 8'h22};
    vecs[7] = '{"h12h0000abcdg", "0000abce\n", 32'h0000abcd, 1, 8'h08};
    vecs[8] = '{"hg",            "?",          32'h0,        0, 8'h20};

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table of commands, idle transmitter
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Slow transmitter: busy for 20 cycles after every strobe
    busy_mode = 1'b1;
    base = n_strobes;
    run_vec(vecs[0]);
    check("busy_strobe_count", n_strobes - base == 9, 64'(n_strobes - base), 64'd9);
    busy_mode = 1'b0;
    repeat (25) @(negedge clk);

    // Datapath never completes: '?' exactly TIMEOUT cycles after dp_start
    dp_hang = 1'b1;
    push_resp("?");
    q_op.push_back(32'h00000005);
    sbase = n_starts;
    send_str("h00000005g");
    wait_tx_empty(200);
    repeat (4) @(negedge clk);
    check("timeout_start_seen", n_starts - sbase == 1, 64'(n_starts - sbase), 64'd1);
    check("timeout_latency", last_strobe_cyc - start_cyc == TIMEOUT,
          64'(last_strobe_cyc - start_cyc), 64'(TIMEOUT));
    check("timeout_ledout", ledout == 8'h48, 64'(ledout), 64'h48);
    dp_hang = 1'b0;
    q_op.delete();

    // Uppercase digits, plus a stray byte while waiting on the datapath
    push_resp("abcdeff1\n");
    q_op.push_back(32'hABCDEFF0);
    sbase = n_starts;
    send_str("hABCDEFF0g");
    n = 0;
    while (n_starts == sbase && n < 50) begin
      @(negedge clk);
      n++;
    end
    send_byte(8'h78);
    wait_tx_empty(200);
    repeat (4) @(negedge clk);
    check("drop_ledout", ledout == 8'h88, 64'(ledout), 64'h88);
    q_op.delete();

    // Reset in the middle of the hex reply
    push_resp("91230002\n");
    q_op.push_back(32'h91230001);
    base = n_strobes;
    send_str("h91230001g");
    n = 0;
    while (n_strobes < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_point", n_strobes == base + 3, 64'(n_strobes - base), 64'd3);
    rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    q_tx.delete();
    q_op.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base  = n_strobes;
    sbase = n_starts;
    repeat (50) @(negedge clk);
    check("no_tx_after_reset", n_strobes == base, 64'(n_strobes - base), 64'd0);
    check("no_start_after_reset", n_starts == sbase, 64'(n_starts - sbase), 64'd0);
    run_vec(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
